// File: rtl/vga_pattern_engine_if.sv
// Command-in / video-out bundle for vga_pattern_engine.
// The master side drives commands and receives video; the engine is the slave.
interface vga_pattern_engine_if #(
   parameter int unsigned VIDEO_WIDTH = 4
);
   logic                   i_Cmd_DV;
   logic [7:0]             i_Cmd_Byte;
   logic                   o_HSync;
   logic                   o_VSync;
   logic                   o_Active;
   logic [VIDEO_WIDTH-1:0] o_Red_Video;
   logic [VIDEO_WIDTH-1:0] o_Grn_Video;
   logic [VIDEO_WIDTH-1:0] o_Blu_Video;
   logic                   o_Frame_Start;
   logic [3:0]             o_Pattern;

   modport master (
      output i_Cmd_DV, i_Cmd_Byte,
      input  o_HSync, o_VSync, o_Active, o_Red_Video, o_Grn_Video, o_Blu_Video,
             o_Frame_Start, o_Pattern
   );

   modport slave (
      input  i_Cmd_DV, i_Cmd_Byte,
      output o_HSync, o_VSync, o_Active, o_Red_Video, o_Grn_Video, o_Blu_Video,
             o_Frame_Start, o_Pattern
   );
endinterface

// File: rtl/vga_pattern_engine.sv
// VGA timing and test-pattern engine.
// Stage 0: column/row/bar counters.  Stage 1: position decode.  Stage 2: colour and
// registered outputs.  Every output is two clocks behind the counters, so sync, active,
// colour and frame-start stay aligned.  Commands land in pending registers and are
// copied to the active set only when the counters sit at (col 0, row 0).
// Optional feature: define VGA_PATTERN_ANIM_EN to enable the moving bar of pattern 8.
module vga_pattern_engine #(
   parameter int unsigned VIDEO_WIDTH = 4,
   parameter int unsigned ACTIVE_COLS = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned ACTIVE_ROWS = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter bit          SYNC_POL    = 1'b0
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   vga_pattern_engine_if.slave  bus
);

   localparam int unsigned TOTAL_COLS = ACTIVE_COLS + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned TOTAL_ROWS = ACTIVE_ROWS + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned CW         = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1;
   localparam int unsigned RW         = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;
   localparam int unsigned HS_START   = ACTIVE_COLS + H_FRONT;
   localparam int unsigned HS_END     = HS_START + H_SYNC;
   localparam int unsigned VS_START   = ACTIVE_ROWS + V_FRONT;
   localparam int unsigned VS_END     = VS_START + V_SYNC;
   localparam int unsigned BAR_W      = ACTIVE_COLS / 8;
   localparam int unsigned BW         = (BAR_W > 1) ? $clog2(BAR_W) : 1;
`ifdef VGA_PATTERN_ANIM_EN
   localparam int unsigned ANIM_STEP  = 4;
   localparam int unsigned ANIM_W     = 16;
   localparam int unsigned POS_MAX    = ACTIVE_COLS - ANIM_W;
   localparam int unsigned PW         = $clog2(ACTIVE_COLS);
`endif

   // Stage 0 counters
   logic [CW-1:0]  r_col;
   logic [RW-1:0]  r_row;
   logic [BW-1:0]  r_bar_cnt;
   logic [2:0]     r_bar_idx;
   logic           w_frame_start;

   // Pending and active configuration
   logic [3:0]     r_pat_pend;
   logic [3:0]     r_pat_act;
   logic [2:0]     r_fg_pend;
   logic [2:0]     r_fg_act;

   // Stage 1 decode
   logic           w_vis;
   logic           w_hs_on;
   logic           w_vs_on;
   logic           w_chk;
   logic           w_border;
   logic           r_s1_active;
   logic           r_s1_hsync;
   logic           r_s1_vsync;
   logic           r_s1_frame;
   logic           r_s1_chk;
   logic           r_s1_border;
   logic [2:0]     r_s1_bar_idx;

   // Stage 2 colour (R,G,B bits)
   logic [2:0]     w_rgb;

`ifdef VGA_PATTERN_ANIM_EN
   logic [PW-1:0]  r_bar_pos;
   logic [PW-1:0]  r_bar_pos_act;
   logic [31:0]    w_pos_adv;
   logic [CW-1:0]  r_s1_col;
   logic           w_anim_hit;
`endif

   assign w_frame_start = (r_col == '0) && (r_row == '0);

   // Raster counters plus a per-bar counter so the colour-bar index needs no divider
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_col     <= '0;
         r_row     <= '0;
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
      end else if (r_col == CW'(TOTAL_COLS - 1)) begin
         r_col     <= '0;
         r_bar_cnt <= '0;
         r_bar_idx <= '0;
         r_row     <= (r_row == RW'(TOTAL_ROWS - 1)) ? '0 : r_row + RW'(1);
      end else begin
         r_col <= r_col + CW'(1);
         if (r_bar_cnt == BW'(BAR_W - 1)) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
         end else begin
            r_bar_cnt <= r_bar_cnt + BW'(1);
         end
      end
   end

   // Command capture into pending registers; frame-start copy to the active set
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_pat_pend <= 4'd0;
         r_pat_act  <= 4'd0;
         r_fg_pend  <= 3'b111;
         r_fg_act   <= 3'b111;
      end else begin
         if (w_frame_start) begin
            r_pat_act <= r_pat_pend;
            r_fg_act  <= r_fg_pend;
         end
         if (bus.i_Cmd_DV) begin
            case (bus.i_Cmd_Byte[7:4])
               4'h0:    r_pat_pend <= bus.i_Cmd_Byte[3:0];
               4'h1:    r_fg_pend  <= bus.i_Cmd_Byte[2:0];
               default: ;
            endcase
         end
      end
   end

`ifdef VGA_PATTERN_ANIM_EN
   assign w_pos_adv = 32'(r_bar_pos) + ANIM_STEP;

   // Bar position: the frame being started shows the current value, the next one advances
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_bar_pos     <= '0;
         r_bar_pos_act <= '0;
      end else if (w_frame_start) begin
         r_bar_pos_act <= r_bar_pos;
         r_bar_pos     <= (w_pos_adv > POS_MAX) ? '0 : PW'(w_pos_adv);
      end
   end
`endif

   assign w_vis    = (32'(r_col) < ACTIVE_COLS) && (32'(r_row) < ACTIVE_ROWS);
   assign w_hs_on  = (32'(r_col) >= HS_START) && (32'(r_col) < HS_END);
   assign w_vs_on  = (32'(r_row) >= VS_START) && (32'(r_row) < VS_END);
   assign w_chk    = ((32'(r_col) & 32'd32) != 32'd0) ^ ((32'(r_row) & 32'd32) != 32'd0);
   assign w_border = (r_col == '0) || (32'(r_col) == ACTIVE_COLS - 1) ||
                     (r_row == '0) || (32'(r_row) == ACTIVE_ROWS - 1);

   // Stage 1: register position-derived flags
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_s1_active  <= 1'b0;
         r_s1_hsync   <= 1'b0;
         r_s1_vsync   <= 1'b0;
         r_s1_frame   <= 1'b0;
         r_s1_chk     <= 1'b0;
         r_s1_border  <= 1'b0;
         r_s1_bar_idx <= 3'd0;
`ifdef VGA_PATTERN_ANIM_EN
         r_s1_col     <= '0;
`endif
      end else begin
         r_s1_active  <= w_vis;
         r_s1_hsync   <= w_hs_on;
         r_s1_vsync   <= w_vs_on;
         r_s1_frame   <= w_frame_start;
         r_s1_chk     <= w_chk;
         r_s1_border  <= w_border;
         r_s1_bar_idx <= r_bar_idx;
`ifdef VGA_PATTERN_ANIM_EN
         r_s1_col     <= r_col;
`endif
      end
   end

`ifdef VGA_PATTERN_ANIM_EN
   assign w_anim_hit = (32'(r_s1_col) >= 32'(r_bar_pos_act)) &&
                       (32'(r_s1_col) <  32'(r_bar_pos_act) + ANIM_W);
`endif

   // Stage 2 colour select; everything outside the visible area is black
   always_comb begin
      w_rgb = 3'b000;
      if (r_s1_active) begin
         case (r_pat_act)
            4'd1: w_rgb = r_fg_act;
            4'd2: w_rgb = 3'b100;
            4'd3: w_rgb = 3'b010;
            4'd4: w_rgb = 3'b001;
            4'd5: if (r_s1_chk) w_rgb = r_fg_act;
            4'd6: begin
               case (r_s1_bar_idx)
                  3'd0: w_rgb = 3'b111;
                  3'd1: w_rgb = 3'b110;
                  3'd2: w_rgb = 3'b011;
                  3'd3: w_rgb = 3'b010;
                  3'd4: w_rgb = 3'b101;
                  3'd5: w_rgb = 3'b100;
                  3'd6: w_rgb = 3'b001;
                  3'd7: w_rgb = 3'b000;
               endcase
            end
            4'd7: if (r_s1_border) w_rgb = r_fg_act;
`ifdef VGA_PATTERN_ANIM_EN
            4'd8: if (w_anim_hit) w_rgb = r_fg_act;
`endif
            default: w_rgb = 3'b000;
         endcase
      end
   end

   // Stage 2 output registers
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         bus.o_HSync       <= ~SYNC_POL;
         bus.o_VSync       <= ~SYNC_POL;
         bus.o_Active      <= 1'b0;
         bus.o_Red_Video   <= '0;
         bus.o_Grn_Video   <= '0;
         bus.o_Blu_Video   <= '0;
         bus.o_Frame_Start <= 1'b0;
         bus.o_Pattern     <= 4'd0;
      end else begin
         bus.o_HSync       <= r_s1_hsync ? SYNC_POL : ~SYNC_POL;
         bus.o_VSync       <= r_s1_vsync ? SYNC_POL : ~SYNC_POL;
         bus.o_Active      <= r_s1_active;
         bus.o_Red_Video   <= {VIDEO_WIDTH{w_rgb[2]}};
         bus.o_Grn_Video   <= {VIDEO_WIDTH{w_rgb[1]}};
         bus.o_Blu_Video   <= {VIDEO_WIDTH{w_rgb[0]}};
         bus.o_Frame_Start <= r_s1_frame;
         bus.o_Pattern     <= r_pat_act;
      end
   end

endmodule

// File: doc/vga_pattern_engine.md
# vga_pattern_engine

Parametrised VGA timing and test-pattern engine: one block generating programmable-porch sync timing, nine selectable patterns with a programmable foreground colour, and frame-synchronous command application from a byte stream (the UART RX DV/byte pair). It sits between the UART receiver and the board VGA pins. It replaces the separate sync-pulse, pattern-generator and porch stages with one pipelined block whose sync and video are aligned by construction.

## Interface
- VIDEO_WIDTH, 4, bits per colour channel
- ACTIVE_COLS, 640, visible pixels per line; multiple of 8
- H_FRONT, 16; H_SYNC, 96; H_BACK, 48; horizontal porch/sync widths in clocks
- ACTIVE_ROWS, 480, visible lines
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33; vertical porch/sync widths in lines
- SYNC_POL, 0, sync assertion level: 0 active-low, 1 active-high
- i_Clk  in  1  pixel clock, all logic on rising edge
- i_Rst_L  in  1  asynchronous active-low reset
- i_Cmd_DV  in  1  one-cycle strobe, i_Cmd_Byte valid
- i_Cmd_Byte  in  8  command byte
- o_HSync  out  1  horizontal sync, polarity per SYNC_POL
- o_VSync  out  1  vertical sync, polarity per SYNC_POL
- o_Active  out  1  high during visible pixels
- o_Red_Video, o_Grn_Video, o_Blu_Video  out  VIDEO_WIDTH each  pixel colour; zero outside the visible area
- o_Frame_Start  out  1  one-cycle pulse aligned with the first visible pixel (col 0, row 0) on the outputs
- o_Pattern  out  4  pattern index currently displayed

## Operation
- TOTAL_COLS = ACTIVE_COLS+H_FRONT+H_SYNC+H_BACK; TOTAL_ROWS similarly.
- Column counter 0..TOTAL_COLS-1 wraps to 0 and advances the row counter. The row counter wraps at TOTAL_ROWS-1.
- Visible area: col < ACTIVE_COLS and row < ACTIVE_ROWS.
- HSync asserted for ACTIVE_COLS+H_FRONT ≤ col < ACTIVE_COLS+H_FRONT+H_SYNC.
- VSync asserted for the same window on rows, using the V_* parameters; it changes only at col 0.
- Command decode on i_Cmd_DV:
  - i_Cmd_Byte[7:4]=0x0: pending pattern ← [3:0]
  - 0x1: pending foreground ← [2:0] (R,G,B bits; each channel becomes all-ones or zero)
  - other opcodes ignored
  - Multiple commands within a frame: last one wins.
- Pending values are copied to active registers on the cycle the counters are at (col 0, row 0). The display never changes mid-frame.
- Patterns (active index), all outside-visible-area pixels black:
  - 0: black
  - 1: solid foreground
  - 2: solid red
  - 3: solid green
  - 4: solid blue
  - 5: 32×32 checkerboard, foreground where col[5]^row[5]=1, else black
  - 6: eight colour bars of ACTIVE_COLS/8 px: white, yellow, cyan, green, magenta, red, blue, black. Bar index comes from a bar counter, not a divider.
  - 7: 1-px foreground border (col 0, col ACTIVE_COLS-1, row 0, row ACTIVE_ROWS-1), black interior
  - 8: moving bar (see Configuration)
  - 9–15: black

## Timing
- Reset values:
  - counters 0
  - o_HSync/o_VSync at the deasserted level (~SYNC_POL)
  - o_Active 0, colours 0, o_Frame_Start 0
  - o_Pattern 0
  - foreground 3'b111; pending registers equal active registers
- Pipeline latency is 2 clocks from counter to every output. Sync, o_Active, colours and o_Frame_Start are delayed identically, so no output is skewed relative to another.
- The command strobe is accepted on any cycle with no back-pressure.
- A command in the same cycle as the frame-start copy is not applied in that frame. It is held pending and applied at the next frame start.
- o_Pattern changes in the same output cycle as o_Frame_Start.
- Reset mid-frame: all state returns to reset values immediately. The first o_Frame_Start occurs 2 clocks after reset deasserts.

## Configuration
- VGA_PATTERN_ANIM_EN defined:
  - adds a bar-position register, reset 0
  - at each frame start the position advances by 4; it wraps to 0 when the new value would exceed ACTIVE_COLS-16
  - pattern 8 draws a 16-px wide full-height foreground bar with its left edge at that position, black elsewhere
- Not defined: register absent; pattern 8 renders black. Ports are identical in both builds.

## Test plan
- Reset, default parameters, no commands:
  - HSync low 96 clocks every 800, VSync low 2 lines every 525
  - o_Frame_Start period 420000 clocks
  - colours 0 (pattern 0)
- SYNC_POL=1, H_SYNC=44, V_SYNC=5: syncs idle low and pulse high for exactly 44 clocks and 5 lines. The visible area is unchanged.
- Command 0x06 mid-frame:
  - o_Pattern stays 0 until the next o_Frame_Start
  - then bar k (80 px wide) shows the listed colour, e.g. col 80 = yellow (F,F,0), col 639 = black
- Commands 0x12 then 0x05 in one frame: next frame is a checkerboard with green F at (32,0) and black at (0,0).
- Command 0x01 presented on the exact frame-start copy cycle: not applied that frame; applied at the following o_Frame_Start.
- With VGA_PATTERN_ANIM_EN and pattern 8: bar left edge at 0, 4, 8 on successive frames; it wraps to 0 after 624. Without the macro, pattern 8 gives an all-black frame.
